memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares one single-port RAM between the CPU fetch port (iren/iaddr) and the data port
//  (dren/dwen/daddr). Sits between the datapath's cpu_ram port and the RAM.
//  Serialises requests: data has priority over fetch. Reports completion through
//  iwait/dwait. Flags RAM acks that never arrive.
// PARAMETERS
//  MAX_WAIT   255           cycles in BUSY without ram_ack before timeout; 0 = timeout disabled
//  ERR_DATA   32'hDEADBEEF  load value returned on timeout
// PORTS
//  clk        in   1   clock
//  nrst       in   1   asynchronous active-low reset
//  iren       in   1   fetch request
//  iaddr      in   32  fetch address
//  iload      out  32  fetch data, valid when iwait=0
//  iwait      out  1   0 = fetch complete this cycle
//  dren       in   1   data read request
//  dwen       in   4   data byte write enables; nonzero = write request
//  daddr      in   32  data address
//  dstore     in   32  write data, pre-aligned by the datapath
//  dload      out  32  read data, valid when dwait=0
//  dwait      out  1   0 = data access complete this cycle
//  ram_req    out  1   RAM request, held until ram_ack
//  ram_ren    out  1   RAM read strobe
//  ram_wen    out  4   RAM byte write enables
//  ram_addr   out  32  RAM word address; {addr[31:2],2'b00}
//  ram_wdata  out  32  RAM write data
//  ram_rdata  in   32  RAM read data, valid with ram_ack
//  ram_ack    in   1   single-cycle completion from RAM
//  bus_err    out  1   sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  - States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
//  - Reset (async, any state): state=IDLE; all RAM outputs 0; iload=dload=0;
//    iwait=dwait=1; bus_err=0; wait counter=0. Any in-flight access is abandoned.
//  - IDLE transitions:
//    - data request (dren | |dwen) -> BUSY_D; else iren -> BUSY_I; else stay IDLE.
//    - On entering BUSY, latch addr, rw kind, dwen and dstore into registers.
//  - BUSY_x outputs:
//    - ram_req=1; ram_addr, ram_ren, ram_wen and ram_wdata driven from the latched registers.
//    - Fetch: ren=1, wen=0.
//    - Data: if dwen!=0, wen=dwen and ren=0 (a write wins over a simultaneous dren);
//      otherwise ren=1.
//    - Latched values stay stable while ram_req=1.
//  - BUSY_x exit:
//    - ram_ack -> DONE_x, capture ram_rdata (reads only) into iload or dload.
//    - Counter reaching MAX_WAIT (MAX_WAIT!=0) -> DONE_x with load=ERR_DATA and bus_err<=1;
//      ram_req drops.
//    - Wait counter is cleared on entry to BUSY.
//  - DONE_D (one cycle):
//    - dwait=0 if the current request matches the latch (same daddr, same kind, same dwen);
//      else dwait stays 1.
//    - Next state is always IDLE. A mismatched request is re-arbitrated; a write already sent
//      to RAM is not rolled back.
//  - DONE_I (one cycle):
//    - iwait=0 only if iren=1 and iaddr equals the latched address; else iwait stays 1.
//    - A stale fetch after a branch is discarded silently. Next state = IDLE.
//  - Latency: request seen in IDLE at cycle N, ram_ack at cycle N+1 -> wait low at N+2
//    (minimum 3 cycles request-to-done). ram_ack in the same cycle as entering BUSY is
//    impossible, since ram_req is registered.
//  - Priority and fairness:
//    - Data always wins in IDLE. Fetch cannot starve: the pipeline stalls data issue
//      while fetch is pending.
//    - No cross-requester preemption once BUSY.
//  - ram_ack outside BUSY is ignored. iload/dload hold their last value outside DONE.
// TESTING
//  - Fetch only: iren=1, iaddr=0x100, ram_ack 2 cycles after ram_req with rdata=0x00000013
//    -> iwait=0 for one cycle, iload=0x13.
//  - Collision: iren and dren asserted together in IDLE -> data served first (ram_addr=daddr),
//    then fetch; dwait falls before iwait.
//  - Byte write: dwen=4'b0100, daddr=0x202, dstore=0x00AB0000 -> ram_wen=0100,
//    ram_addr=0x200, ram_ren=0, dwait=0 after ack.
//  - Stale fetch: iaddr changes 0x40->0x80 during BUSY_I -> no iwait=0 for 0x40;
//    new fetch issued with ram_addr=0x80.
//  - Timeout (MAX_WAIT=4): no ram_ack -> ram_req drops after 4 cycles, dload=0xDEADBEEF,
//    dwait=0, bus_err=1 until reset.
//  - Reset mid-BUSY_D: nrst low -> ram_req=0 immediately, iwait=dwait=1;
//    after release the arbiter re-issues from IDLE.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port RAM between the CPU fetch and data ports.
// Data wins in IDLE; completion is signalled on iwait/dwait; lost RAM acks raise bus_err.
module memory_arbiter #(
  parameter int unsigned MAX_WAIT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ram_req,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   lat_addr, lat_addr_n;
  logic [BW-1:0]   lat_wen, lat_wen_n;
  logic [CW-1:0]   wait_cnt, wait_cnt_n;
  logic            ram_req_n, ram_ren_n;
  logic [BW-1:0]   ram_wen_n;
  logic [AW-1:0]   ram_addr_n, ram_wdata_n;
  logic [AW-1:0]   iload_n, dload_n;
  logic            bus_err_n;

  logic dreq_c, timeout_c, dmatch_c, imatch_c;

  assign dreq_c    = dren || (dwen != '0);
  assign timeout_c = (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT - 1));
  // The CPU still holding the latched request is how it accepts the completion.
  assign dmatch_c  = (daddr == lat_addr) && (dwen == lat_wen) && ((lat_wen != '0) || dren);
  assign imatch_c  = iren && (iaddr == lat_addr);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wen   <= '0;
      wait_cnt  <= '0;
      ram_req   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      iload     <= '0;
      dload     <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_n;
      lat_addr  <= lat_addr_n;
      lat_wen   <= lat_wen_n;
      wait_cnt  <= wait_cnt_n;
      ram_req   <= ram_req_n;
      ram_ren   <= ram_ren_n;
      ram_wen   <= ram_wen_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      iload     <= iload_n;
      dload     <= dload_n;
      bus_err   <= bus_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    lat_addr_n  = lat_addr;
    lat_wen_n   = lat_wen;
    wait_cnt_n  = wait_cnt;
    ram_req_n   = ram_req;
    ram_ren_n   = ram_ren;
    ram_wen_n   = ram_wen;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    iload_n     = iload;
    dload_n     = dload;
    bus_err_n   = bus_err;
    iwait       = 1'b1;
    dwait       = 1'b1;

    unique case (state)
      IDLE: begin
        wait_cnt_n = '0;
        if (dreq_c) begin
          state_n     = BUSY_D;
          lat_addr_n  = daddr;
          lat_wen_n   = dwen;
          ram_req_n   = 1'b1;
          ram_ren_n   = (dwen == '0);
          ram_wen_n   = dwen;
          ram_addr_n  = {daddr[AW-1:2], 2'b00};
          ram_wdata_n = dstore;
        end else if (iren) begin
          state_n     = BUSY_I;
          lat_addr_n  = iaddr;
          lat_wen_n   = '0;
          ram_req_n   = 1'b1;
          ram_ren_n   = 1'b1;
          ram_wen_n   = '0;
          ram_addr_n  = {iaddr[AW-1:2], 2'b00};
          ram_wdata_n = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack arriving on the last allowed cycle still counts as success.
        if (ram_ack || timeout_c) begin
          state_n     = (state == BUSY_I) ? DONE_I : DONE_D;
          ram_req_n   = 1'b0;
          ram_ren_n   = 1'b0;
          ram_wen_n   = '0;
          ram_addr_n  = '0;
          ram_wdata_n = '0;
          if (ram_ack) begin
            if (ram_ren) begin
              if (state == BUSY_I) iload_n = ram_rdata;
              else                 dload_n = ram_rdata;
            end
          end else begin
            if (state == BUSY_I) iload_n = ERR_DATA;
            else                 dload_n = ERR_DATA;
            bus_err_n = 1'b1;
          end
        end else begin
          wait_cnt_n = wait_cnt + CW'(1);
        end
      end
      DONE_I: begin
        iwait   = !imatch_c;
        state_n = IDLE;
      end
      DONE_D: begin
        dwait   = !dmatch_c;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios plus random traffic,
// checked against a word-addressed memory model and an ordered list of RAM transactions.
module tb_memory_arbiter;

  localparam int unsigned MAXW = 4;
  localparam logic [31:0] ERRV = 32'hDEADBEEF;

  logic        clk;
  logic        nrst;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dren;
  logic [3:0]  dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_req;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        bus_err;

  memory_arbiter #(.MAX_WAIT(MAXW), .ERR_DATA(ERRV)) dut (
    .clk(clk), .nrst(nrst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ram_req(ram_req), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic        ren;
    logic [31:0] wdata;
  } ram_exp_t;

  ram_exp_t    rq[$];
  logic [31:0] dq[$];
  logic [31:0] iq[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] ram_mem   [logic [31:0]];
  logic [31:0] last_dload, last_iload;
  logic        exp_err;
  int          vectors = 0;
  int          miscompares = 0;
  int          force_delay = -1;
  bit          no_ack = 1'b0;

  function automatic logic [31:0] ram_init(input logic [31:0] w);
    return {w[15:0], ~w[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [3:0] wen,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return model_mem.exists(w) ? model_mem[w] : ram_init(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic push_ram(input logic [31:0] a, input logic [3:0] wen, input logic ren,
                          input logic [31:0] wd);
    ram_exp_t e;
    e.addr = {a[31:2], 2'b00};
    e.wen = wen;
    e.ren = ren;
    e.wdata = wd;
    rq.push_back(e);
  endtask

  // Writes update the model and leave dload alone; reads return the model word.
  task automatic issue_data(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd);
    if (wen != 4'b0) begin
      push_ram(a, wen, 1'b0, wd);
      model_mem[a >> 2] = merge(model_read(a), wen, wd);
    end else begin
      push_ram(a, 4'b0, 1'b1, wd);
      last_dload = model_read(a);
    end
    dq.push_back(last_dload);
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    push_ram(a, 4'b0, 1'b1, 32'h0);
    last_iload = model_read(a);
    iq.push_back(last_iload);
  endtask

  task automatic wait_low(input bit is_d, output time t);
    bit done;
    done = 1'b0;
    t = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if ((is_d ? dwait : iwait) === 1'b0) begin
        done = 1'b1;
        t = $time;
      end
    end
    if (!done) fail_bound(is_d ? "dwait_bound" : "iwait_bound");
  endtask

  task automatic data_op(input logic rd, input logic [3:0] wen, input logic [31:0] a,
                         input logic [31:0] wd, output time t);
    @(posedge clk); #1;
    dren = rd; dwen = wen; daddr = a; dstore = wd;
    wait_low(1'b1, t);
    @(posedge clk); #1;
    dren = 1'b0; dwen = 4'b0;
  endtask

  task automatic fetch_op(input logic [31:0] a, output time t);
    @(posedge clk); #1;
    iren = 1'b1; iaddr = a;
    wait_low(1'b0, t);
    @(posedge clk); #1;
    iren = 1'b0;
  endtask

  // RAM device: checks each new request against the expected order, acks after a delay.
  int          rcnt;
  bit          rseen;
  logic [31:0] rword;
  initial begin
    ram_ack = 1'b0;
    ram_rdata = 32'h0;
    rseen = 1'b0;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (ram_ack) begin
        ram_ack = 1'b0;
        rseen = 1'b0;
      end else if (ram_req !== 1'b1) begin
        rseen = 1'b0;
      end else begin
        if (!rseen) begin
          rseen = 1'b1;
          rcnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
          if (rq.size() == 0) begin
            fail_bound("ram_unexpected_req");
          end else begin
            ram_exp_t e;
            e = rq.pop_front();
            check("ram_addr", ram_addr, e.addr);
            check("ram_wen", 32'(ram_wen), 32'(e.wen));
            check("ram_ren", 32'(ram_ren), 32'(e.ren));
            if (e.wen != 4'b0) check("ram_wdata", ram_wdata, e.wdata);
          end
        end
        if (!no_ack) begin
          if (rcnt == 0) begin
            rword = ram_addr >> 2;
            if (ram_wen != 4'b0)
              ram_mem[rword] = merge(ram_mem.exists(rword) ? ram_mem[rword] : ram_init(rword),
                                     ram_wen, ram_wdata);
            ram_rdata = ram_ren ? (ram_mem.exists(rword) ? ram_mem[rword] : ram_init(rword))
                                : $urandom;
            ram_ack = 1'b1;
          end else begin
            rcnt--;
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard whenever a port reports done.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (dwait === 1'b0) begin
        if (dq.size() == 0) fail_bound("dwait_unexpected");
        else check("dload", dload, dq.pop_front());
        check("bus_err_d", 32'(bus_err), 32'(exp_err));
      end
      if (iwait === 1'b0) begin
        if (iq.size() == 0) fail_bound("iwait_unexpected");
        else check("iload", iload, iq.pop_front());
        check("bus_err_i", 32'(bus_err), 32'(exp_err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  time         t_d, t_i;
  int          op, req_cycles;
  bit          got;
  logic [31:0] ra, rb, wd;
  logic [3:0]  rw;
  logic        rdn;

  task automatic random_op();
    op = int'($urandom_range(0, 3));
    ra = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
    rb = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
    wd = $urandom;
    rw = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
    rdn = (rw == 4'b0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (op)
      0: begin
        issue_fetch(rb);
        fetch_op(rb, t_i);
      end
      1, 2: begin
        ra = ra + 32'($urandom_range(0, 3));
        issue_data(rw, ra, wd);
        data_op(rdn, rw, ra, wd, t_d);
      end
      default: begin
        issue_data(rw, ra, wd);
        issue_fetch(rb);
        fork
          data_op(rdn, rw, ra, wd, t_d);
          fetch_op(rb, t_i);
        join
      end
    endcase
  endtask

  initial begin
    nrst = 1'b0;
    iren = 1'b0; iaddr = 32'h0;
    dren = 1'b0; dwen = 4'b0; daddr = 32'h0; dstore = 32'h0;
    last_dload = 32'h0; last_iload = 32'h0; exp_err = 1'b0;
    model_mem[32'h40] = 32'h00000013;
    ram_mem[32'h40]   = 32'h00000013;
    #2;
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_ren", 32'(ram_ren), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_iload", iload, 32'h0);
    check("rst_dload", dload, 32'h0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Fetch only, ack two cycles after the request.
    force_delay = 2;
    issue_fetch(32'h100);
    fetch_op(32'h100, t_i);
    force_delay = -1;
    check("fetch_iload_13", iload, 32'h13);
    check("fetch_iwait_one_cycle", 32'(iwait), 32'd1);

    // Collision: data is served first.
    issue_data(4'b0, 32'h208, 32'h0);
    issue_fetch(32'h104);
    fork
      data_op(1'b1, 4'b0, 32'h208, 32'h0, t_d);
      fetch_op(32'h104, t_i);
    join
    check("collision_dwait_first", 32'(t_d < t_i), 32'd1);

    // Byte write, then read back the merged word.
    issue_data(4'b0100, 32'h202, 32'h00AB0000);
    data_op(1'b0, 4'b0100, 32'h202, 32'h00AB0000, t_d);
    issue_data(4'b0, 32'h200, 32'h0);
    data_op(1'b1, 4'b0, 32'h200, 32'h0, t_d);

    // Stale fetch: address moves during BUSY, only the new one completes.
    force_delay = 2;
    push_ram(32'h40, 4'b0, 1'b1, 32'h0);
    issue_fetch(32'h80);
    @(posedge clk); #1;
    iren = 1'b1; iaddr = 32'h40;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ram_req === 1'b1) got = 1'b1;
    end
    if (!got) fail_bound("stale_req");
    @(posedge clk); #1;
    iaddr = 32'h80;
    wait_low(1'b0, t_i);
    @(posedge clk); #1;
    iren = 1'b0;
    force_delay = -1;

    for (int k = 0; k < 40; k++) random_op();

    // Timeout on a data read.
    no_ack = 1'b1;
    exp_err = 1'b1;
    push_ram(32'h300, 4'b0, 1'b1, 32'h0);
    last_dload = ERRV;
    dq.push_back(ERRV);
    req_cycles = 0;
    fork
      data_op(1'b1, 4'b0, 32'h300, 32'h0, t_d);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ram_req === 1'b1) req_cycles++;
      end
    join
    no_ack = 1'b0;
    check("timeout_req_cycles", 32'(req_cycles), 32'd4);
    check("timeout_dload", dload, ERRV);

    for (int k = 0; k < 10; k++) random_op();
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of a data access; the held request is re-issued.
    no_ack = 1'b1;
    push_ram(32'h20C, 4'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    dren = 1'b1; daddr = 32'h20C;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (ram_req === 1'b1) got = 1'b1;
    end
    if (!got) fail_bound("reset_busy_req");
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_ram_req", 32'(ram_req), 32'd0);
    check("midrst_iwait", 32'(iwait), 32'd1);
    check("midrst_dwait", 32'(dwait), 32'd1);
    check("midrst_dload", dload, 32'h0);
    check("midrst_bus_err", 32'(bus_err), 32'd0);
    dq.delete();
    exp_err = 1'b0;
    last_dload = 32'h0;
    last_iload = 32'h0;
    no_ack = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    issue_data(4'b0, 32'h20C, 32'h0);
    wait_low(1'b1, t_d);
    @(posedge clk); #1;
    dren = 1'b0;

    repeat (4) @(posedge clk);
    check("left_ram_exp", 32'(rq.size()), 32'd0);
    check("left_data_exp", 32'(dq.size()), 32'd0);
    check("left_fetch_exp", 32'(iq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
